// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package writeback_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Which producer a grant (or the last grant) went to.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    // Writes to x0 are accepted from a source but never reach the register file.
    function automatic logic writes_reg(input reg_addr_t rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Decode, ALU, load/store and register file port bundle around the writeback arbiter.
interface writeback_arbiter_if #(
    parameter int WORD_SIZE = 32
);
    import writeback_arbiter_pkg::*;

    logic                 issue_valid;
    reg_addr_t            issue_rd;
    logic                 issue_ready;
    reg_addr_t            rs1;
    reg_addr_t            rs2;
    logic                 hazard;
    logic                 alu_valid;
    reg_addr_t            alu_rd;
    logic [WORD_SIZE-1:0] alu_data;
    logic                 alu_ready;
    logic                 mem_valid;
    reg_addr_t            mem_rd;
    logic [WORD_SIZE-1:0] mem_data;
    logic                 mem_ready;
    logic                 wr_en;
    reg_addr_t            wr_rd;
    logic [WORD_SIZE-1:0] wr_data;
    logic                 fwd1_valid;
    logic [WORD_SIZE-1:0] fwd1_data;
    logic                 fwd2_valid;
    logic [WORD_SIZE-1:0] fwd2_data;

    // Producer/decode side.
    modport master (
        output issue_valid, issue_rd, rs1, rs2,
               alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  issue_ready, hazard, alu_ready, mem_ready,
               wr_en, wr_rd, wr_data, fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
    );

    // Arbiter side.
    modport slave (
        input  issue_valid, issue_rd, rs1, rs2,
               alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output issue_ready, hazard, alu_ready, mem_ready,
               wr_en, wr_rd, wr_data, fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
    );

endinterface

// File: rtl/writeback_arbiter_scoreboard.sv
// Per-register pending scoreboard: set on issue, cleared on the register file write.
module wb_scoreboard
    import writeback_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      issue_valid,
    input  reg_addr_t issue_rd,
    input  logic      wr_en,
    input  reg_addr_t wr_rd,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    input  logic      fwd1_valid,
    input  logic      fwd2_valid,
    output logic      issue_ready,
    output logic      hazard
);

    logic [REG_COUNT-1:0] pending_q, pending_d;

    // Lookups; the reset gate keeps issue_ready low while the block is held in reset.
    assign issue_ready = rst && !pending_q[issue_rd];
    assign hazard      = (pending_q[rs1] && !fwd1_valid) || (pending_q[rs2] && !fwd2_valid);

    // Clear first, then set, so a same-edge set of the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_en) begin
            pending_d[wr_rd] = 1'b0;
        end
        if (issue_valid && issue_ready && writes_reg(issue_rd)) begin
            pending_d[issue_rd] = 1'b1;
        end
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: round-robin merge of ALU and load results onto the single
// register file write port, with pending scoreboard for decode hazards.
// Optional build macro WRITEBACK_BYPASS_EN forwards the in-commit write to rs1/rs2.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic               clk,
    input  logic               rst,
    writeback_arbiter_if.slave bus
);

    typedef struct packed {
        logic                 en;
        reg_addr_t            rd;
        logic [WORD_SIZE-1:0] data;
    } wb_rec_t;

    src_e    rr_last_q, rr_last_d;
    wb_rec_t wb_q, wb_d;
    logic    grant_alu, grant_mem, xfer;

    // Round-robin grant: memory wins a conflict whenever the ALU went last.
    always_comb begin
        grant_mem = bus.mem_valid && (!bus.alu_valid || rr_last_q == SRC_ALU);
        grant_alu = bus.alu_valid && !grant_mem;
        xfer      = grant_alu || grant_mem;
    end

    assign bus.alu_ready = rst && grant_alu;
    assign bus.mem_ready = rst && grant_mem;

    // Next write record and arbitration history; x0 transfers complete without a write.
    always_comb begin
        rr_last_d = rr_last_q;
        if (xfer) begin
            rr_last_d = grant_mem ? SRC_MEM : SRC_ALU;
        end
        wb_d.rd   = grant_mem ? bus.mem_rd   : bus.alu_rd;
        wb_d.data = grant_mem ? bus.mem_data : bus.alu_data;
        wb_d.en   = xfer && writes_reg(wb_d.rd);
    end

    // Output register reloads every cycle; reset drops any in-flight write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_q <= SRC_ALU;
            wb_q      <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            wb_q      <= wb_d;
        end
    end

    assign bus.wr_en   = wb_q.en;
    assign bus.wr_rd   = wb_q.rd;
    assign bus.wr_data = wb_q.data;

`ifdef WRITEBACK_BYPASS_EN
    // The register file still returns the old value during the commit cycle.
    assign bus.fwd1_valid = rst && wb_q.en && wb_q.rd == bus.rs1 && writes_reg(bus.rs1);
    assign bus.fwd2_valid = rst && wb_q.en && wb_q.rd == bus.rs2 && writes_reg(bus.rs2);
    assign bus.fwd1_data  = wb_q.data;
    assign bus.fwd2_data  = wb_q.data;
`else
    assign bus.fwd1_valid = 1'b0;
    assign bus.fwd2_valid = 1'b0;
    assign bus.fwd1_data  = '0;
    assign bus.fwd2_data  = '0;
`endif

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .wr_en       (wb_q.en),
        .wr_rd       (wb_q.rd),
        .rs1         (bus.rs1),
        .rs2         (bus.rs2),
        .fwd1_valid  (bus.fwd1_valid),
        .fwd2_valid  (bus.fwd2_valid),
        .issue_ready (bus.issue_ready),
        .hazard      (bus.hazard)
    );

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus randomized traffic against
// a cycle-level reference model. Bypass expectations follow WRITEBACK_BYPASS_EN.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.WORD_SIZE(32)) bus();
    writeback_arbiter #(.WORD_SIZE(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: pending set, who was granted last, and the write now visible.
    bit          m_pend [32];
    bit          m_last_mem;
    bit          m_wen;
    int          m_wrd;
    logic [31:0] m_wdata;
    bit          g_alu, g_mem;

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_last_mem = 1'b0;
        m_wen = 1'b0; m_wrd = 0; m_wdata = '0;
        g_alu = 1'b0; g_mem = 1'b0;
    endtask

    // Compare everything visible this cycle, then move the model across the edge.
    task automatic check_cycle();
        bit f1, f2, ir, hz;
        g_alu = 1'b0; g_mem = 1'b0;
        if (bus.alu_valid && bus.mem_valid) begin
            if (m_last_mem) g_alu = 1'b1; else g_mem = 1'b1;
        end else if (bus.alu_valid) g_alu = 1'b1;
        else if (bus.mem_valid) g_mem = 1'b1;
        f1 = 1'b0; f2 = 1'b0;
`ifdef WRITEBACK_BYPASS_EN
        f1 = m_wen && m_wrd == int'(bus.rs1) && bus.rs1 != 0;
        f2 = m_wen && m_wrd == int'(bus.rs2) && bus.rs2 != 0;
`endif
        ir = !m_pend[bus.issue_rd];
        hz = (m_pend[bus.rs1] && !f1) || (m_pend[bus.rs2] && !f2);
        chk("alu_ready", 32'(bus.alu_ready), 32'(g_alu));
        chk("mem_ready", 32'(bus.mem_ready), 32'(g_mem));
        chk("issue_ready", 32'(bus.issue_ready), 32'(ir));
        chk("hazard", 32'(bus.hazard), 32'(hz));
        chk("fwd1_valid", 32'(bus.fwd1_valid), 32'(f1));
        chk("fwd2_valid", 32'(bus.fwd2_valid), 32'(f2));
        if (f1) chk("fwd1_data", bus.fwd1_data, m_wdata);
        if (f2) chk("fwd2_data", bus.fwd2_data, m_wdata);
        chk("wr_en", 32'(bus.wr_en), 32'(m_wen));
        if (m_wen) begin
            chk("wr_rd", 32'(bus.wr_rd), 32'(m_wrd));
            chk("wr_data", bus.wr_data, m_wdata);
        end
        if (m_wen) m_pend[m_wrd] = 1'b0;
        if (bus.issue_valid && ir && bus.issue_rd != 0) m_pend[bus.issue_rd] = 1'b1;
        if (g_alu || g_mem) m_last_mem = g_mem;
        m_wen = 1'b0;
        if (g_alu && bus.alu_rd != 0) begin
            m_wen = 1'b1; m_wrd = int'(bus.alu_rd); m_wdata = bus.alu_data;
        end
        if (g_mem && bus.mem_rd != 0) begin
            m_wen = 1'b1; m_wrd = int'(bus.mem_rd); m_wdata = bus.mem_data;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    endtask

    // Random traffic; a source keeps its request until the model says it was taken.
    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (g_alu || !bus.alu_valid) begin
                bus.alu_valid = ($urandom_range(0, 2) != 0);
                bus.alu_rd    = 5'($urandom_range(0, 7));
                bus.alu_data  = $urandom;
            end
            if (g_mem || !bus.mem_valid) begin
                bus.mem_valid = ($urandom_range(0, 2) != 0);
                bus.mem_rd    = 5'($urandom_range(0, 7));
                bus.mem_data  = $urandom;
            end
            bus.issue_valid = ($urandom_range(0, 1) != 0);
            bus.issue_rd    = 5'($urandom_range(0, 7));
            bus.rs1         = 5'($urandom_range(0, 7));
            bus.rs2         = 5'($urandom_range(0, 7));
            tick();
            adv();
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #1;
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_rd", 32'(bus.wr_rd), 32'd0);
        chk("rst_wr_data", bus.wr_data, 32'd0);
        chk("rst_issue_ready", 32'(bus.issue_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        adv();

        // Single ALU result, visible on the write port one cycle later.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        tick();
        chk("t1_alu_ready", 32'(bus.alu_ready), 32'd1);
        adv();
        bus.alu_valid = 1'b0;
        tick();
        chk("t1_wr_en", 32'(bus.wr_en), 32'd1);
        chk("t1_wr_rd", 32'(bus.wr_rd), 32'd5);
        chk("t1_wr_data", bus.wr_data, 32'hDEADBEEF);
        adv();

        // Both sources for four cycles: MEM, ALU, MEM, ALU.
        for (int i = 0; i < 5; i++) begin
            bus.alu_valid = (i < 4); bus.alu_rd = 5'd1; bus.alu_data = 32'h100 + 32'(i);
            bus.mem_valid = (i < 4); bus.mem_rd = 5'd2; bus.mem_data = 32'h200 + 32'(i);
            tick();
            if (i < 4) chk("t2_mem_ready", 32'(bus.mem_ready), 32'((i % 2) == 0));
            if (i > 0) chk("t2_wr_rd", 32'(bus.wr_rd), (i % 2 == 1) ? 32'd2 : 32'd1);
            adv();
        end
        idle_inputs();

        // WAW block on x7 until the cycle after its write.
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        tick();
        chk("t3_first_issue", 32'(bus.issue_ready), 32'd1);
        adv();
        bus.rs1 = 5'd7;
        tick();
        chk("t3_waw_block", 32'(bus.issue_ready), 32'd0);
        chk("t3_hazard", 32'(bus.hazard), 32'd1);
        adv();
        bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
        tick();
        adv();
        bus.alu_valid = 1'b0;
        tick();
        chk("t3_wr_rd", 32'(bus.wr_rd), 32'd7);
        chk("t3_still_pending", 32'(bus.issue_ready), 32'd0);
        adv();
        tick();
        chk("t3_released", 32'(bus.issue_ready), 32'd1);
        chk("t3_hazard_gone", 32'(bus.hazard), 32'd0);
        adv();
        idle_inputs();

        // x0 result: accepted, never written.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
        tick();
        chk("t4_alu_ready", 32'(bus.alu_ready), 32'd1);
        adv();
        bus.alu_valid = 1'b0;
        tick();
        chk("t4_wr_en", 32'(bus.wr_en), 32'd0);
        adv();

        // Bypass of x3 during its commit cycle.
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        tick();
        adv();
        bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hA5;
        tick();
        adv();
        bus.alu_valid = 1'b0; bus.rs2 = 5'd3;
        tick();
`ifdef WRITEBACK_BYPASS_EN
        chk("t5_fwd2_valid", 32'(bus.fwd2_valid), 32'd1);
        chk("t5_fwd2_data", bus.fwd2_data, 32'hA5);
        chk("t5_hazard", 32'(bus.hazard), 32'd0);
`else
        chk("t5_fwd2_valid", 32'(bus.fwd2_valid), 32'd0);
        chk("t5_hazard", 32'(bus.hazard), 32'd1);
`endif
        adv();
        idle_inputs();
        tick();
        adv();

        rand_cycles(600);

        // Reset while a write is in flight.
        idle_inputs();
        tick();
        adv();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'hCAFE0009;
        tick();
        adv();
        bus.issue_valid = 1'b0;
        bus.alu_rd = 5'd10;
        chk("t6_wr_en_before", 32'(bus.wr_en), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_wr_en_dropped", 32'(bus.wr_en), 32'd0);
        chk("t6_alu_ready_rst", 32'(bus.alu_ready), 32'd0);
        chk("t6_fwd1_rst", 32'(bus.fwd1_valid), 32'd0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        adv();
        bus.issue_rd = 5'd12; bus.rs1 = 5'd12; bus.rs2 = 5'd9;
        tick();
        chk("t6_pending_clear", 32'(bus.issue_ready), 32'd1);
        chk("t6_hazard_clear", 32'(bus.hazard), 32'd0);
        adv();

        rand_cycles(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
